fifo_rr_scheduler: RTL and testbench

- Round-robin drain scheduler for NUM_QUEUES independent fifo_v3 instances.
- Watches each FIFO's empty flag and issues pops to the granted FIFO.
- Forwards popped entries through one registered valid/ready output slot, tagged with the source index.
- Each grant is capped at QUANTUM consecutive pops, giving fair bandwidth sharing toward a single downstream consumer.

---
 rtl/fifo_sched_pkg.sv | 14 +
 rtl/fifo_rr_scheduler_if.sv | 15 +
 rtl/fifo_rr_scheduler_rr_select.sv | 26 ++
 rtl/fifo_rr_scheduler.sv | 114 +++++++++++
 tb/tb_fifo_rr_scheduler.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the FIFO drain scheduler family.
// Pure declarations; no timing or flow-control behaviour of its own.
package fifo_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } sched_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_scheduler_if.sv
// Single-slot valid/ready output bus carrying a payload and its source index.
// The master holds data/idx stable while valid is high and ready is low.
interface fifo_rr_scheduler_if #(
    parameter int  DATA_WIDTH = 32,
    parameter int  IDX_WIDTH  = 2,
    parameter type dtype      = logic [DATA_WIDTH-1:0]
);
    logic                 valid;
    logic                 ready;
    dtype                 data;
    logic [IDX_WIDTH-1:0] idx;

    modport master (output valid, data, idx, input ready);
    modport slave  (input valid, data, idx, output ready);
endinterface

// File: rtl/fifo_rr_scheduler_rr_select.sv
// Combinational round-robin pick: first set request strictly after last_i, wrapping.
// Zero latency; no flow control.
module rr_select #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          vld_o,
    output logic [IW-1:0] idx_o
);
    int j;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        vld_o = |req_i;
        idx_o = '0;
        j     = 0;
        for (int off = N; off >= 1; off--) begin
            j = (int'(last_i) + off) % N;
            if (req_i[IW'(j)]) begin
                idx_o = IW'(j);
            end
        end
    end
endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin drain of NUM_QUEUES FIFOs, QUANTUM pops per grant, one bubble per grant switch.
// Payload appears one cycle after its pop; pops stall while the output slot is held by ~ready.
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int  NUM_QUEUES = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  QUANTUM    = 4,
    parameter type dtype      = logic [DATA_WIDTH-1:0],
    parameter int  IDX_WIDTH  = idx_width(NUM_QUEUES)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [NUM_QUEUES-1:0] empty_i,
    input  dtype                  data_i [NUM_QUEUES],
    output logic [NUM_QUEUES-1:0] pop_o,
    output logic                  busy_o,
    fifo_rr_scheduler_if.master   out_if
);
    localparam int CNT_WIDTH = $clog2(QUANTUM + 1);

    if (QUANTUM < 1) begin : g_bad_quantum
        $error("QUANTUM must be >= 1");
    end
    if (NUM_QUEUES < 1) begin : g_bad_queues
        $error("NUM_QUEUES must be >= 1");
    end

    sched_state_e         state_q;
    logic [IDX_WIDTH-1:0] grant_q;
    logic [IDX_WIDTH-1:0] last_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 valid_q;
    dtype                 data_q;
    logic [IDX_WIDTH-1:0] idx_q;

    logic                 sel_vld;
    logic [IDX_WIDTH-1:0] sel_idx;
    logic                 load;
    logic                 do_pop;
    logic                 last_pop;

    rr_select #(.N(NUM_QUEUES), .IW(IDX_WIDTH)) u_rr_select (
        .req_i  (~empty_i),
        .last_i (last_q),
        .vld_o  (sel_vld),
        .idx_o  (sel_idx)
    );

    assign load     = ~valid_q | out_if.ready;
    assign do_pop   = (state_q == SERVE) & ~empty_i[grant_q] & load & ~rst_i & ~flush_i;
    assign last_pop = (cnt_q + 1'b1) == CNT_WIDTH'(QUANTUM);

    always_comb begin
        pop_o = '0;
        if (do_pop) begin
            pop_o[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_WIDTH'(NUM_QUEUES - 1);
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= IDX_WIDTH'(NUM_QUEUES - 1);
        end else begin
            if (do_pop) begin
                data_q  <= data_i[grant_q];
                idx_q   <= grant_q;
                valid_q <= 1'b1;
                cnt_q   <= cnt_q + 1'b1;
            end else if (out_if.ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        grant_q <= sel_idx;
                        cnt_q   <= '0;
                        state_q <= SERVE;
                    end
                end
                SERVE: begin
                    // An early-empty queue forfeits the rest of its quantum.
                    if (empty_i[grant_q] || (do_pop && last_pop)) begin
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_if.valid = valid_q;
    assign out_if.data  = data_q;
    assign out_if.idx   = idx_q;
    assign busy_o       = (state_q == SERVE) | valid_q;

    a_pop_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(pop_o));
    a_pop_nonempty: assert property (@(posedge clk_i) disable iff (rst_i) (pop_o & empty_i) == '0);
    a_slot_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (out_if.valid & ~out_if.ready) |=> ($stable(out_if.data) && $stable(out_if.idx)));
endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench: behavioural FIFOs feed the scheduler; outputs checked against hand-computed values.
module tb_fifo_rr_scheduler;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic        flush_i;
    logic [3:0]  empty_i;
    logic [31:0] data_i [4];
    logic [3:0]  pop_o;
    logic        busy_o;

    fifo_rr_scheduler_if #(.DATA_WIDTH(32), .IDX_WIDTH(2)) out_if ();

    fifo_rr_scheduler #(.NUM_QUEUES(4), .DATA_WIDTH(32), .QUANTUM(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .empty_i (empty_i),
        .data_i  (data_i),
        .pop_o   (pop_o),
        .busy_o  (busy_o),
        .out_if  (out_if)
    );

    logic [31:0] fq [4][$];
    logic [3:0]  pop_seen;
    int          total = 0;
    int          bad = 0;
    int          cycle_no = 0;
    int          pops_total = 0;
    logic [1:0]  log_idx [$];
    logic [31:0] log_dat [$];
    int          log_cyc [$];

    always @(posedge clk) begin
        pop_seen <= pop_o;
        if (out_if.valid && out_if.ready) begin
            log_idx.push_back(out_if.idx);
            log_dat.push_back(out_if.data);
            log_cyc.push_back(cycle_no);
        end
    end

    typedef struct {
        logic        rdy;
        logic [3:0]  pop;
        logic        vld;
        logic [1:0]  idx;
        logic [31:0] dat;
        logic        busy;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            empty_i[i] = (fq[i].size() == 0);
            data_i[i]  = (fq[i].size() > 0) ? fq[i][0] : 32'h0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pop_seen[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        end
        if (pop_seen != 4'b0) pops_total++;
        cycle_no++;
        refresh();
        #1;
    endtask

    task automatic clear_log();
        log_idx.delete();
        log_dat.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        flush_i = 1'b0;
        out_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) fq[i].delete();
        refresh();
        cyc();
        cyc();
        rst_i = 1'b0;
        pops_total = 0;
    endtask

    initial begin
        vt[0] = '{1'b1, 4'b0100, 1'b0, 2'd0, 32'h0,  1'b1};
        vt[1] = '{1'b1, 4'b0100, 1'b1, 2'd2, 32'hA0, 1'b1};
        vt[2] = '{1'b1, 4'b0100, 1'b1, 2'd2, 32'hB0, 1'b1};
        vt[3] = '{1'b1, 4'b0000, 1'b1, 2'd2, 32'hC0, 1'b1};
        vt[4] = '{1'b1, 4'b0000, 1'b0, 2'd2, 32'hC0, 1'b0};
        vt[5] = '{1'b1, 4'b0000, 1'b0, 2'd2, 32'hC0, 1'b0};

        // Reset state, then pops suppressed while reset is held.
        rst_i = 1'b1;
        flush_i = 1'b0;
        out_if.ready = 1'b1;
        pop_seen = 4'b0;
        refresh();
        cyc();
        cyc();
        chk("rst_valid", 32'(out_if.valid), 32'h0);
        chk("rst_pop", 32'(pop_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_idx", 32'(out_if.idx), 32'h0);
        chk("rst_data", out_if.data, 32'h0);
        fq[0].push_back(32'h5);
        refresh();
        #1;
        chk("rst_hold_pop0", 32'(pop_o), 32'h0);
        cyc();
        chk("rst_hold_pop1", 32'(pop_o), 32'h0);
        chk("rst_hold_busy", 32'(busy_o), 32'h0);

        // Single source: FIFO 2 holds A0, B0, C0.
        fq[0].delete();
        fq[2].push_back(32'hA0);
        fq[2].push_back(32'hB0);
        fq[2].push_back(32'hC0);
        refresh();
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            out_if.ready = vt[i].rdy;
            cyc();
            chk($sformatf("single_pop[%0d]", i), 32'(pop_o), 32'(vt[i].pop));
            chk($sformatf("single_vld[%0d]", i), 32'(out_if.valid), 32'(vt[i].vld));
            chk($sformatf("single_idx[%0d]", i), 32'(out_if.idx), 32'(vt[i].idx));
            chk($sformatf("single_dat[%0d]", i), out_if.data, vt[i].dat);
            chk($sformatf("single_busy[%0d]", i), 32'(busy_o), 32'(vt[i].busy));
        end

        // Fairness: four full FIFOs of 10 entries each.
        do_reset();
        for (int q = 0; q < 4; q++)
            for (int k = 0; k < 10; k++) fq[q].push_back(32'(q * 256 + k));
        refresh();
        clear_log();
        repeat (80) cyc();
        chk("fair_count", 32'(log_idx.size()), 32'd40);
        if (log_idx.size() == 40) begin
            int n = 0;
            for (int r = 0; r < 3; r++)
                for (int q = 0; q < 4; q++)
                    for (int k = 0; k < ((r < 2) ? 4 : 2); k++) begin
                        chk($sformatf("fair_idx[%0d]", n), 32'(log_idx[n]), 32'(q));
                        chk($sformatf("fair_dat[%0d]", n), log_dat[n], 32'(q * 256 + r * 4 + k));
                        n++;
                    end
            chk("fair_span32", 32'(log_cyc[31] - log_cyc[0]), 32'd38);
            chk("fair_gap", 32'(log_cyc[32] - log_cyc[31]), 32'd2);
        end
        chk("fair_drained", 32'(fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()), 32'd0);
        chk("fair_idle", 32'(busy_o), 32'h0);

        // Backpressure mid-burst from FIFO 1.
        do_reset();
        for (int k = 0; k < 6; k++) fq[1].push_back(32'h100 + 32'(k));
        refresh();
        cyc();
        cyc();
        chk("bp_d0", out_if.data, 32'h100);
        cyc();
        chk("bp_d1", out_if.data, 32'h101);
        chk("bp_pops2", 32'(pops_total), 32'd2);
        out_if.ready = 1'b0;
        #1;
        chk("bp_stall_pop", 32'(pop_o), 32'h0);
        for (int s = 0; s < 5; s++) begin
            cyc();
            chk($sformatf("bp_pop[%0d]", s), 32'(pop_o), 32'h0);
            chk($sformatf("bp_dat[%0d]", s), out_if.data, 32'h101);
            chk($sformatf("bp_idx[%0d]", s), 32'(out_if.idx), 32'd1);
            chk($sformatf("bp_vld[%0d]", s), 32'(out_if.valid), 32'd1);
        end
        chk("bp_pops_held", 32'(pops_total), 32'd2);
        out_if.ready = 1'b1;
        cyc();
        chk("bp_d2", out_if.data, 32'h102);
        cyc();
        chk("bp_d3", out_if.data, 32'h103);
        chk("bp_pops4", 32'(pops_total), 32'd4);
        chk("bp_quantum_end", 32'(pop_o), 32'h0);
        cyc();
        chk("bp_regrant", 32'(pop_o), 32'b0010);

        // Flush after two pops from FIFO 1; next grant restarts at 0.
        do_reset();
        for (int k = 0; k < 6; k++) fq[1].push_back(32'h100 + 32'(k));
        refresh();
        cyc();
        cyc();
        cyc();
        fq[0].push_back(32'h55);
        refresh();
        flush_i = 1'b1;
        #1;
        chk("fl_pop_in_flush", 32'(pop_o), 32'h0);
        cyc();
        flush_i = 1'b0;
        #1;
        chk("fl_valid", 32'(out_if.valid), 32'h0);
        chk("fl_busy", 32'(busy_o), 32'h0);
        chk("fl_pop_idle", 32'(pop_o), 32'h0);
        cyc();
        chk("fl_grant0", 32'(pop_o), 32'b0001);
        cyc();
        chk("fl_out_vld", 32'(out_if.valid), 32'h1);
        chk("fl_out_idx", 32'(out_if.idx), 32'h0);
        chk("fl_out_dat", out_if.data, 32'h55);

        // Wrap from grant 3 to 0, early empty on FIFO 0, then back to 3.
        do_reset();
        for (int k = 0; k < 4; k++) fq[3].push_back(32'h300 + 32'(k));
        refresh();
        repeat (5) cyc();
        fq[0].push_back(32'h10);
        fq[0].push_back(32'h11);
        fq[3].push_back(32'h310);
        fq[3].push_back(32'h311);
        fq[3].push_back(32'h312);
        refresh();
        cyc();
        chk("wr_grant0", 32'(pop_o), 32'b0001);
        clear_log();
        cyc();
        cyc();
        chk("wr_early_empty", 32'(pop_o), 32'h0);
        cyc();
        chk("wr_idle", 32'(pop_o), 32'h0);
        cyc();
        chk("wr_grant3", 32'(pop_o), 32'b1000);
        repeat (6) cyc();
        chk("wr_count", 32'(log_idx.size()), 32'd5);
        if (log_idx.size() == 5) begin
            logic [1:0]  ei [5];
            logic [31:0] ed [5];
            ei = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd3};
            ed = '{32'h10, 32'h11, 32'h310, 32'h311, 32'h312};
            for (int n = 0; n < 5; n++) begin
                chk($sformatf("wr_idx[%0d]", n), 32'(log_idx[n]), 32'(ei[n]));
                chk($sformatf("wr_dat[%0d]", n), log_dat[n], ed[n]);
            end
        end
        chk("wr_idle_end", 32'(busy_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
